uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
UART transmitter with an internal byte FIFO. It accepts bytes from on-chip logic, such as neural-network result writers, and serialises them onto a single tx line as 8N1 frames (or 8E1, see Optional Feature). It is the transmit-side counterpart to the team's UART receive path. It is baud-compatible with the existing uart block at the same clock_frequency/baud_rate, so an existing uart instance can be used as the bench probe.

Parameters:
clock_frequency, 12000000, clk frequency in Hz
baud_rate, 9600, line rate in bit/s; bit period DIV = clock_frequency/baud_rate, integer-truncated (1250 at defaults)
fifo_depth_log2, 3, FIFO holds 2**fifo_depth_log2 bytes (8 at default)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
clear  input  1  synchronous clear of the overflow flag only
wr_en  input  1  push wr_data into the FIFO this cycle
wr_data  input  8  byte to transmit
full  output  1  FIFO holds 2**fifo_depth_log2 bytes
empty  output  1  FIFO holds 0 bytes
level  output  fifo_depth_log2+1  current FIFO occupancy
overflow  output  1  sticky; set when a write was dropped
tx_busy  output  1  high while a frame is on the line
tx  output  1  serial output, idle high
sent_cnt  output  8  count of completed frames, wraps 255->0

Behaviour:
- Reset (rst high at a rising edge), effective at the next edge:
  - tx=1, tx_busy=0, full=0, empty=1, level=0, overflow=0, sent_cnt=0.
  - FIFO pointers are zeroed and state goes to IDLE.
  - Reset mid-frame abandons the frame; tx returns high one cycle later; queued bytes are discarded.
- FIFO:
  - full, empty and level are registered and reflect the contents after each edge.
  - A write is accepted only when full=0 at that edge.
  - wr_en with full=1 drops the byte and sets overflow, even if a pop happens in the same cycle.
  - Simultaneous accepted write and pop leaves level unchanged.
  - Pointers wrap modulo depth.
  - overflow clears only on rst or clear. If clear and a dropped write coincide, overflow stays set.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the option).
  - IDLE: tx=1, tx_busy=0. If empty=0, pop the head byte into the shift register, go to START, and reset the bit-timer to 0.
  - START: tx=0 for exactly DIV cycles.
  - DATA: 8 bits, LSB first, each held exactly DIV cycles; a 3-bit index counts 0..7.
  - STOP: tx=1 for DIV cycles. At the end of STOP, sent_cnt increments. If empty=0 at that edge, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Bit-timer: counts 0..DIV-1 and advances the state on DIV-1. Width is clog2(DIV).
- Latency:
  - A byte written into an idle, empty block is accepted at edge N and visible at N+1 (empty=0).
  - It is popped at N+1; tx falls and tx_busy rises after edge N+2.
  - Frame length is 10*DIV cycles.
- tx_busy is high from the START entry edge until the edge that returns the FSM to IDLE. It stays high across back-to-back frames.
- wr_data is sampled only at the accepting edge; later changes do not affect queued bytes.
- tx is driven from a flop (glitch-free).

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = XOR of the 8 data bits (even parity), held DIV cycles. Frame = 11*DIV cycles.
- Undefined: no PARITY state or logic. Frame = 10*DIV cycles.

Test Plan:
- Reset then write 0xAB once -> tx low 2 cycles after the write edge. Per-DIV samples: 0,1,1,0,1,0,1,0,1,1. tx_busy high 12500 cycles. sent_cnt=1. uart probe reports 0xAB with error=0.
- Burst of 8 writes on consecutive cycles (AB CD EF 15 77 34 43 6B) -> level reaches 7 then drains. Frames are back-to-back with tx_busy never dropping, for 100000 cycles total. Probe receives all 8 bytes in order; sent_cnt=8.
- 9 writes on consecutive cycles while idle -> the first write is popped, so all 9 are accepted and overflow=0. Then 2 more writes while full=1 -> overflow=1 and those bytes are never sent. clear pulse -> overflow=0.
- Assert rst for 1 cycle midway through the DATA bits of 0x15 with 3 bytes queued -> tx=1, tx_busy=0, level=0 next cycle. No further frames; the probe sees a framing error or nothing.
- 256 single-byte frames -> sent_cnt wraps to 0.
- With UART_TX_PARITY_EN: send 0xAB -> parity sample=1, frame 13750 cycles. Send 0x33 -> parity sample=0.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - UART transmitter with an internal byte FIFO
//
// Bytes pushed with wr_en are queued in a 2**fifo_depth_log2 deep FIFO and
// serialised LSB first as 8N1 frames. Frames run back to back while the FIFO
// holds data. tx and tx_busy are registered copies of the FSM state, so both
// lag the state register by one cycle and tx never glitches.
//
// Optional build macro UART_TX_PARITY_EN: inserts an even-parity bit between
// the last data bit and the stop bit (8E1, 11 bit periods per frame).
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset (drops the frame and the queue)
//   clear     synchronous clear of the sticky overflow flag
//   wr_en     push wr_data this cycle (ignored and flagged when full)
//   wr_data   byte to transmit
//   full      FIFO holds 2**fifo_depth_log2 bytes (registered)
//   empty     FIFO holds no bytes (registered)
//   level     FIFO occupancy (registered)
//   overflow  sticky, set when a write was dropped
//   tx_busy   high while a frame is on the line
//   tx        serial line, idle high
//   sent_cnt  completed frames, wraps 255 -> 0
module uart_tx_buffered #(
  parameter int clock_frequency = 12000000,
  parameter int baud_rate       = 9600,
  parameter int fifo_depth_log2 = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [fifo_depth_log2:0] level,
  output logic                     overflow,
  output logic                     tx_busy,
  output logic                     tx,
  output logic [7:0]               sent_cnt
);

  localparam int DIV   = clock_frequency / baud_rate;
  localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << fifo_depth_log2;
  localparam int LW    = fifo_depth_log2 + 1;

  localparam logic [TW-1:0]              TICK_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0]              TIMER_ONE = TW'(1);
  localparam logic [LW-1:0]              LVL_ONE   = LW'(1);
  localparam logic [LW-1:0]              LVL_FULL  = LW'(DEPTH);
  localparam logic [fifo_depth_log2-1:0] PTR_ONE   = fifo_depth_log2'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]                 mem [DEPTH];
  logic [fifo_depth_log2-1:0] wr_ptr;
  logic [fifo_depth_log2-1:0] rd_ptr;
  logic [LW-1:0]              level_d;
  logic                       push;
  logic                       pop;

  // Serialiser
  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          tick;
  logic          tx_d;

  // A write is judged against the registered full flag, so a pop in the
  // same cycle never rescues a write that arrived while full.
  assign push = wr_en && !full;
  assign tick = (timer_q == TICK_LAST);

  always_comb begin
    level_d = level;
    case ({push, pop})
      2'b10:   level_d = level + LVL_ONE;
      2'b01:   level_d = level - LVL_ONE;
      default: level_d = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level <= level_d;
      full  <= (level_d == LVL_FULL);
      empty <= (level_d == '0);
      // A dropped write wins over clear so that no drop goes unreported.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clear) begin
        overflow <= 1'b0;
      end
    end
  end

  // Next state, pop request and the line level the current state calls for.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shreg_q[bit_idx_q];
        if (tick && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = ^shreg_q;
        if (tick) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          // Chain straight into the next frame when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'd0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      sent_cnt  <= 8'd0;
    end else begin
      state_q <= state_d;
      // Timer idles at zero so a frame out of IDLE starts on a full period.
      if ((state_q == S_IDLE) || tick) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TIMER_ONE;
      end
      if (pop) begin
        shreg_q   <= mem[rd_ptr];
        bit_idx_q <= 3'd0;
      end else if ((state_q == S_DATA) && tick) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      if ((state_q == S_STOP) && tick) begin
        sent_cnt <= sent_cnt + 8'd1;
      end
      tx      <= tx_d;
      tx_busy <= (state_q != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

  localparam int CF    = 80;
  localparam int BR    = 10;
  localparam int DIV   = CF / BR;
  localparam int DL2   = 3;
  localparam int DEPTH = 1 << DL2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN  = NBITS * DIV;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clear = 1'b0;
  logic           wr_en = 1'b0;
  logic [7:0]     wr_data = 8'd0;
  logic           full, empty, overflow, tx_busy, tx;
  logic [DL2:0]   level;
  logic [7:0]     sent_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_run = 0;
  int last_run = 0;

  uart_tx_buffered #(
    .clock_frequency(CF),
    .baud_rate(BR),
    .fifo_depth_log2(DL2)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .tx_busy(tx_busy), .tx(tx), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_run <= (tx_busy === 1'b1) ? busy_run + 1 : 0;
    if (tx_busy !== 1'b1 && busy_run != 0) last_run <= busy_run;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of accepted bytes plus the position (in clock cycles) inside the
  // frame currently on the line; the line level is a lookup into the frame.
  logic [7:0] mq[$];
  int         fpos = -1;
  logic [7:0] cur = 8'd0;
  bit         mvalid = 0;
  logic       m_ovf = 1'b0, m_tx = 1'b1, m_busy = 1'b0;
  logic [7:0] m_sent = 8'd0;

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Advance the model across the next rising edge using the inputs now held.
  task automatic model_step();
    bit full_pre, do_pop;
    if (rst) begin
      mq.delete(); fpos = -1; m_ovf = 0; m_sent = 0; m_tx = 1; m_busy = 0; mvalid = 1;
      return;
    end
    if (!mvalid) return;
    m_tx     = (fpos < 0) ? 1'b1 : frame_bit(cur, fpos / DIV);
    m_busy   = (fpos >= 0);
    full_pre = (mq.size() == DEPTH);
    do_pop   = (mq.size() != 0) && (fpos < 0 || fpos == FLEN - 1);
    if (fpos == FLEN - 1) begin m_sent++; fpos = -1; end
    else if (fpos >= 0) fpos++;
    if (do_pop) begin cur = mq.pop_front(); fpos = 0; end
    if (wr_en) begin
      if (full_pre) m_ovf = 1;
      else mq.push_back(wr_data);
    end
    if (clear && !(wr_en && full_pre)) m_ovf = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      check("tx", tx, m_tx);
      check("tx_busy", tx_busy, m_busy);
      check("level", level, mq.size());
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
      check("overflow", overflow, m_ovf);
      check("sent_cnt", sent_cnt, m_sent);
    end
    model_step();
  end

  // ---------------- line probe (mid-bit sampling receiver) ----------------
  logic [7:0] rxq[$];
  bit         rxerr[$];
  initial begin
    logic [7:0] b;
    bit         err;
    forever begin
      @(negedge clk);
      if (mvalid && tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        err = (tx !== 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        if (tx !== ^b) err = 1;
`endif
        repeat (DIV) @(negedge clk);
        if (tx !== 1'b1) err = 1;
        rxq.push_back(b);
        rxerr.push_back(err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic align();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; align(); wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm, output int maxlvl);
    int n = 0, st = 0;
    maxlvl = 0;
    while (st < 3 && n < budget) begin
      @(negedge clk); n++;
      if (level > maxlvl) maxlvl = level;
      if (tx_busy === 1'b0 && empty === 1'b1) st++; else st = 0;
    end
    check({nm, " drains"}, st, 3);
    align();
  endtask

  task automatic check_rx(input string nm, input logic [7:0] exp[$]);
    check({nm, " rx count"}, rxq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rxq.size(); i++) begin
      check({nm, " rx byte"}, rxq[i], exp[i]);
      check({nm, " rx error"}, rxerr[i], 0);
    end
    rxq.delete(); rxerr.delete();
  endtask

  task automatic send_sample(input logic [7:0] d, input logic [10:0] expv, input string nm);
    int w, n, ml;
    logic [10:0] got;
    logic [7:0] e[$];
    align(); wr(d); w = cyc; n = 0;
    while (tx !== 1'b0 && n < 4 * DIV) begin @(negedge clk); n++; end
    check({nm, " latency"}, cyc - w, 2);
    got = '1;
    repeat (DIV / 2) @(negedge clk);
    for (int i = 0; i < NBITS; i++) begin
      got[i] = tx;
      if (i < NBITS - 1) repeat (DIV) @(negedge clk);
    end
    check({nm, " bits"}, got, expv);
    wait_idle(3 * FLEN, nm, ml);
    check({nm, " busy cycles"}, last_run, FLEN);
    e.push_back(d);
    check_rx(nm, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst[$];
    logic [7:0] e[$];
    int ml, cnt, n;

    // reset
    repeat (3) align();
    rst = 1'b0;
    align();
    check("reset tx", tx, 1);
    check("reset busy", tx_busy, 0);
    check("reset empty", empty, 1);
    check("reset level", level, 0);
    check("reset sent", sent_cnt, 0);

    // single frame, 0xAB: 0,1,1,0,1,0,1,0,1,(parity 1),1
    send_sample(8'hAB, 11'h756, "ab");
    check("ab sent", sent_cnt, 1);
`ifdef UART_TX_PARITY_EN
    send_sample(8'h33, 11'h466, "33");
`endif

    // back-to-back burst of 8
    burst = '{8'hAB, 8'hCD, 8'hEF, 8'h15, 8'h77, 8'h34, 8'h43, 8'h6B};
    align();
    foreach (burst[i]) wr(burst[i]);
    wait_idle(12 * FLEN, "burst", ml);
    check("burst max level", ml, 7);
    check("burst busy cycles", last_run, 8 * FLEN);
`ifdef UART_TX_PARITY_EN
    check("burst sent", sent_cnt, 10);
`else
    check("burst sent", sent_cnt, 9);
`endif
    check_rx("burst", burst);

    // fill to full, drop writes, clear
    e.delete();
    align();
    for (int i = 0; i < 9; i++) begin wr(8'h40 + 8'(i)); e.push_back(8'h40 + 8'(i)); end
    check("fill full", full, 1);
    check("fill level", level, 8);
    check("fill overflow", overflow, 0);
    wr(8'hEE); wr(8'hEE);
    check("drop overflow", overflow, 1);
    check("drop level", level, 8);
    clear = 1'b1; wr(8'hEE); clear = 1'b0;
    check("clear+drop overflow", overflow, 1);
    clear = 1'b1; align(); clear = 1'b0;
    check("clear overflow", overflow, 0);
    wait_idle(12 * FLEN, "fill", ml);
    check_rx("fill", e);

    // reset in the middle of the data bits of 0x15
    align();
    wr(8'h15); wr(8'hA1); wr(8'hA2); wr(8'hA3);
    repeat (5 * DIV) align();
    check("pre-reset level", level, 3);
    check("pre-reset busy", tx_busy, 1);
    rst = 1'b1; align(); rst = 1'b0;
    check("mid reset tx", tx, 1);
    check("mid reset busy", tx_busy, 0);
    check("mid reset level", level, 0);
    n = 0;
    for (int i = 0; i < 4 * FLEN; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) n++;
    end
    check("post reset line quiet", n, 0);
    check("post reset sent", sent_cnt, 0);
    rxq.delete(); rxerr.delete();
    align();

    // 256 frames: sent_cnt wraps back to 0
    cnt = 0; n = 0;
    while (cnt < 256 && n < 40000) begin
      if (full === 1'b0) begin wr(8'(cnt)); cnt++; end
      else align();
      n++;
    end
    check("wrap writes", cnt, 256);
    wait_idle(12 * FLEN, "wrap", ml);
    check("wrap sent", sent_cnt, 0);
    check("wrap rx count", rxq.size(), 256);
    if (rxq.size() == 256) begin
      check("wrap first", rxq[0], 8'h00);
      check("wrap last", rxq[255], 8'hFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
